video_timing_gen: RTL and testbench

- Parametrised, runtime-configurable successor to the fixed-timing MIPI video generator.
- Produces hsync/vsync, horizontal/vertical/combined valid, pixel coordinates and frame/line strobes for the CSI-2 TX path.
- Adds shadowed timing registers, enable/stop at frame boundaries, and a lookahead valid (PRE_CYC) plus a delayed valid (DLY_CYC) with matched pipelines.
- Sits between the config register bank and the pixel source / MIPI TX packer.

---
 rtl/video_timing_gen.sv | 218 +++++++++++++++++++++
 tb/tb_video_timing_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Runtime-configurable video timing generator: sync pulses, active-region flags,
// coordinates and strobes, with a lookahead and a delayed data-enable.
module video_timing_gen #(
   parameter int COORD_W    = 16,
   parameter int PRE_CYC    = 2,
   parameter int DLY_CYC    = 1,
   parameter int FCNT_W     = 16,
   parameter int DEF_H_ACT  = 1280,
   parameter int DEF_H_BLK  = 370,
   parameter int DEF_H_SYNC = 40,
   parameter int DEF_V_ACT  = 720,
   parameter int DEF_V_BLK  = 30,
   parameter int DEF_V_SYNC = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [COORD_W-1:0] cfg_h_act,
   input  logic [COORD_W-1:0] cfg_h_blk,
   input  logic [COORD_W-1:0] cfg_h_sync,
   input  logic [COORD_W-1:0] cfg_v_act,
   input  logic [COORD_W-1:0] cfg_v_blk,
   input  logic [COORD_W-1:0] cfg_v_sync,
   input  logic               cfg_update,
   output logic               hsync_o,
   output logic               vsync_o,
   output logic               valid_h_o,
   output logic               valid_v_o,
   output logic               de_o,
   output logic               pre_de_o,
   output logic               de_dly_o,
   output logic               frame_start_o,
   output logic               line_start_o,
   output logic               running_o,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic [FCNT_W-1:0]  frame_cnt
);

   localparam int SW = COORD_W + 1;
   localparam logic [SW-1:0] MAXV = {1'b0, {COORD_W{1'b1}}};
   localparam logic [5:0] TAIL = 6'(1 + PRE_CYC + DLY_CYC);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   typedef struct packed {
      logic [COORD_W-1:0] act;
      logic [COORD_W-1:0] blk;
      logic [COORD_W-1:0] sync;
   } tim_t;

   typedef struct packed {
      logic               hs;
      logic               vs;
      logic               vh;
      logic               vv;
      logic               de;
      logic               fs;
      logic               ls;
      logic [COORD_W-1:0] px;
      logic [COORD_W-1:0] py;
   } pix_t;

   // Zero fields become 1, oversized totals shrink the blank, sync never exceeds blank.
   function automatic tim_t sanitise(input logic [COORD_W-1:0] a,
                                     input logic [COORD_W-1:0] b,
                                     input logic [COORD_W-1:0] s);
      tim_t t;
      logic [SW-1:0] sum;
      logic [SW-1:0] room;
      t.act  = (a == '0) ? COORD_W'(1) : a;
      t.blk  = (b == '0) ? COORD_W'(1) : b;
      t.sync = (s == '0) ? COORD_W'(1) : s;
      sum  = {1'b0, t.act} + {1'b0, t.blk};
      room = MAXV - {1'b0, t.act};
      if (sum > MAXV) t.blk = room[COORD_W-1:0];
      if (t.sync > t.blk) t.sync = t.blk;
      return t;
   endfunction

   state_t             state_q, state_d;
   logic [COORD_W-1:0] hcnt_q, hcnt_d;
   logic [COORD_W-1:0] vcnt_q, vcnt_d;
   tim_t               pend_h_q, pend_v_q;
   tim_t               act_h_q, act_v_q;
   logic               load_act;

   logic [SW-1:0] h_total, v_total;
   logic          h_last, v_last, frame_last, run;

   assign h_total    = {1'b0, act_h_q.act} + {1'b0, act_h_q.blk};
   assign v_total    = {1'b0, act_v_q.act} + {1'b0, act_v_q.blk};
   assign h_last     = ({1'b0, hcnt_q} == h_total - SW'(1));
   assign v_last     = ({1'b0, vcnt_q} == v_total - SW'(1));
   assign frame_last = h_last & v_last;
   assign run        = (state_q != S_IDLE);

   always_comb begin
      state_d  = state_q;
      hcnt_d   = hcnt_q;
      vcnt_d   = vcnt_q;
      load_act = 1'b0;
      case (state_q)
         S_IDLE: begin
            hcnt_d = '0;
            vcnt_d = '0;
            if (enable) begin
               state_d  = S_RUN;
               load_act = 1'b1;
            end
         end
         S_RUN, S_DRAIN: begin
            if (h_last) begin
               hcnt_d = '0;
               vcnt_d = v_last ? '0 : vcnt_q + COORD_W'(1);
            end else begin
               hcnt_d = hcnt_q + COORD_W'(1);
            end
            if (state_q == S_RUN) begin
               if (!enable) state_d = S_DRAIN;
            end else if (enable) begin
               state_d = S_RUN;
            end else if (frame_last) begin
               state_d = S_IDLE;
            end
            // New timing becomes active exactly as the next frame begins.
            if (frame_last && (state_d != S_IDLE)) load_act = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         hcnt_q   <= '0;
         vcnt_q   <= '0;
         pend_h_q <= {COORD_W'(DEF_H_ACT), COORD_W'(DEF_H_BLK), COORD_W'(DEF_H_SYNC)};
         pend_v_q <= {COORD_W'(DEF_V_ACT), COORD_W'(DEF_V_BLK), COORD_W'(DEF_V_SYNC)};
         act_h_q  <= {COORD_W'(DEF_H_ACT), COORD_W'(DEF_H_BLK), COORD_W'(DEF_H_SYNC)};
         act_v_q  <= {COORD_W'(DEF_V_ACT), COORD_W'(DEF_V_BLK), COORD_W'(DEF_V_SYNC)};
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         if (cfg_update) begin
            pend_h_q <= sanitise(cfg_h_act, cfg_h_blk, cfg_h_sync);
            pend_v_q <= sanitise(cfg_v_act, cfg_v_blk, cfg_v_sync);
         end
         if (load_act) begin
            act_h_q <= pend_h_q;
            act_v_q <= pend_v_q;
         end
      end
   end

   // Core flags; IDLE feeds zeros so the pipeline drains cleanly.
   logic [SW-1:0] hc, vc, ha, va, hs_end, vs_end;
   pix_t          pix_d;

   assign hc     = {1'b0, hcnt_q};
   assign vc     = {1'b0, vcnt_q};
   assign ha     = {1'b0, act_h_q.act};
   assign va     = {1'b0, act_v_q.act};
   assign hs_end = ha + {1'b0, act_h_q.sync};
   assign vs_end = va + {1'b0, act_v_q.sync};

   always_comb begin
      pix_d    = '0;
      pix_d.vh = run & (hc < ha);
      pix_d.vv = run & (vc < va);
      pix_d.hs = run & (hc >= ha) & (hc < hs_end);
      pix_d.vs = run & (vc >= va) & (vc < vs_end);
      pix_d.de = pix_d.vh & pix_d.vv;
      pix_d.ls = run & (hcnt_q == '0);
      pix_d.fs = pix_d.ls & (vcnt_q == '0);
      pix_d.px = hcnt_q;
      pix_d.py = vcnt_q;
   end

   // Stage 0 drives pre_de_o; stage PRE_CYC drives every aligned output.
   pix_t               pipe_q [0:PRE_CYC];
   logic               dly_q  [0:DLY_CYC-1];
   logic [FCNT_W-1:0]  fcnt_q;
   logic [5:0]         drain_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i <= PRE_CYC; i++) pipe_q[i] <= '0;
         for (int i = 0; i < DLY_CYC; i++)  dly_q[i]  <= 1'b0;
         fcnt_q  <= '0;
         drain_q <= '0;
      end else begin
         pipe_q[0] <= pix_d;
         for (int i = 1; i <= PRE_CYC; i++) pipe_q[i] <= pipe_q[i-1];
         dly_q[0] <= pipe_q[PRE_CYC].de;
         for (int i = 1; i < DLY_CYC; i++) dly_q[i] <= dly_q[i-1];
         if (pipe_q[PRE_CYC-1].fs) fcnt_q <= fcnt_q + FCNT_W'(1);
         if (run)                   drain_q <= TAIL;
         else if (drain_q != '0)    drain_q <= drain_q - 6'd1;
      end
   end

   assign pre_de_o      = pipe_q[0].de;
   assign hsync_o       = pipe_q[PRE_CYC].hs;
   assign vsync_o       = pipe_q[PRE_CYC].vs;
   assign valid_h_o     = pipe_q[PRE_CYC].vh;
   assign valid_v_o     = pipe_q[PRE_CYC].vv;
   assign de_o          = pipe_q[PRE_CYC].de;
   assign frame_start_o = pipe_q[PRE_CYC].fs;
   assign line_start_o  = pipe_q[PRE_CYC].ls;
   assign x             = pipe_q[PRE_CYC].px;
   assign y             = pipe_q[PRE_CYC].py;
   assign de_dly_o      = dly_q[DLY_CYC-1];
   assign frame_cnt     = fcnt_q;
   assign running_o     = run | (drain_q != '0);

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: expected output events are queued by the
// stimulus process and matched by a monitor watching edges of the DUT outputs.
`timescale 1ns/1ps
module tb_video_timing_gen;

   localparam int W   = 16;
   localparam int PRE = 2;
   localparam int DLY = 1;

   localparam int K_PRE = 0, K_DER = 1, K_DEF = 2, K_DLY = 3, K_HSR = 4;
   localparam int K_HSF = 5, K_VSR = 6, K_VSF = 7, K_FS = 8, K_LS = 9, K_RUNF = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         enable = 1'b0;
   logic         cfg_update = 1'b0;
   logic [W-1:0] cfg_h_act = '0, cfg_h_blk = '0, cfg_h_sync = '0;
   logic [W-1:0] cfg_v_act = '0, cfg_v_blk = '0, cfg_v_sync = '0;
   logic         hsync_o, vsync_o, valid_h_o, valid_v_o, de_o, pre_de_o, de_dly_o;
   logic         frame_start_o, line_start_o, running_o;
   logic [W-1:0] x, y;
   logic [15:0]  frame_cnt;

   video_timing_gen dut (
      .clk(clk), .rst(rst), .enable(enable),
      .cfg_h_act(cfg_h_act), .cfg_h_blk(cfg_h_blk), .cfg_h_sync(cfg_h_sync),
      .cfg_v_act(cfg_v_act), .cfg_v_blk(cfg_v_blk), .cfg_v_sync(cfg_v_sync),
      .cfg_update(cfg_update),
      .hsync_o(hsync_o), .vsync_o(vsync_o), .valid_h_o(valid_h_o), .valid_v_o(valid_v_o),
      .de_o(de_o), .pre_de_o(pre_de_o), .de_dly_o(de_dly_o),
      .frame_start_o(frame_start_o), .line_start_o(line_start_o), .running_o(running_o),
      .x(x), .y(y), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      int k;
      int c;
      int v;
   } ev_t;

   ev_t  evq[$];
   int   checks = 0;
   int   errors = 0;
   logic mon_on = 1'b0;

   task automatic push(input int k, input int c, input int v);
      ev_t e;
      e.k = k;
      e.c = c;
      e.v = v;
      evq.push_back(e);
   endtask

   // Expected events of nl lines of a frame whose pixel (0,0) appears at cycle base.
   task automatic push_frame(input int base, input int ha, input int hb, input int hs,
                             input int va, input int vb, input int vs, input int fc,
                             input int nl);
      int ht, vt, lb;
      ht = ha + hb;
      vt = va + vb;
      push(K_FS, base, fc);
      for (int l = 0; l < nl; l++) begin
         lb = base + l * ht;
         push(K_LS, lb, l);
         if (l < va) begin
            push(K_PRE, lb - PRE, 0);
            push(K_DER, lb, l << 16);
            push(K_DLY, lb + DLY, 0);
            push(K_DEF, lb + ha, ha);
         end
         push(K_HSR, lb + ha, ha);
         push(K_HSF, lb + ha + hs, (ha + hs) % ht);
         if (l == va)      push(K_VSR, lb, va);
         if (l == va + vs) push(K_VSF, lb, l);
      end
   endtask

   task automatic take(input int k, input string nm, input int c, input int v);
      int idx;
      idx = -1;
      for (int i = 0; i < evq.size(); i++) begin
         if (evq[i].k == k) begin
            idx = i;
            break;
         end
      end
      checks++;
      if (idx < 0) begin
         errors++;
         $display("FAIL %s unexpected at cycle %0d value %0d", nm, c, v);
      end else begin
         if (evq[idx].c != c || evq[idx].v != v) begin
            errors++;
            $display("FAIL %s got cycle %0d value %0d, required cycle %0d value %0d",
                     nm, c, v, evq[idx].c, evq[idx].v);
         end
         evq.delete(idx);
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h required %0h", nm, got, exp);
      end
   endtask

   logic p_pre = 0, p_de = 0, p_dly = 0, p_hs = 0, p_vs = 0, p_fs = 0, p_ls = 0, p_run = 0;

   always @(negedge clk) begin
      if (mon_on) begin
         if (pre_de_o && !p_pre)       take(K_PRE, "pre_de_rise", cyc, 0);
         if (de_o && !p_de)            take(K_DER, "de_rise", cyc, int'({y, x}));
         if (!de_o && p_de)            take(K_DEF, "de_fall", cyc, int'(x));
         if (de_dly_o && !p_dly)       take(K_DLY, "de_dly_rise", cyc, 0);
         if (hsync_o && !p_hs)         take(K_HSR, "hsync_rise", cyc, int'(x));
         if (!hsync_o && p_hs)         take(K_HSF, "hsync_fall", cyc, int'(x));
         if (vsync_o && !p_vs)         take(K_VSR, "vsync_rise", cyc, int'(y));
         if (!vsync_o && p_vs)         take(K_VSF, "vsync_fall", cyc, int'(y));
         if (frame_start_o && !p_fs)   take(K_FS, "frame_start", cyc, int'(frame_cnt));
         if (line_start_o && !p_ls)    take(K_LS, "line_start", cyc, int'(y));
         if (!running_o && p_run)      take(K_RUNF, "running_fall", cyc, 0);
      end
      p_pre = pre_de_o;
      p_de  = de_o;
      p_dly = de_dly_o;
      p_hs  = hsync_o;
      p_vs  = vsync_o;
      p_fs  = frame_start_o;
      p_ls  = line_start_o;
      p_run = running_o;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   function automatic logic [63:0] all_outs();
      return {6'b0, hsync_o, vsync_o, valid_h_o, valid_v_o, de_o, pre_de_o, de_dly_o,
              frame_start_o, line_start_o, running_o, x, y, frame_cnt};
   endfunction

   task automatic set_cfg(input int ha, input int hb, input int hs,
                          input int va, input int vb, input int vs);
      cfg_h_act  = W'(ha);
      cfg_h_blk  = W'(hb);
      cfg_h_sync = W'(hs);
      cfg_v_act  = W'(va);
      cfg_v_blk  = W'(vb);
      cfg_v_sync = W'(vs);
      cfg_update = 1'b1;
      tick();
      cfg_update = 1'b0;
   endtask

   // Default timing from reset: first line plus the start of the second, then a mid-line reset.
   task automatic default_run();
      int n, base;
      tick();
      n = cyc;
      enable = 1'b1;
      base = n + 4;
      mon_on = 1'b1;
      push_frame(base, 1280, 370, 40, 720, 30, 5, 1, 1);
      push(K_LS, base + 1650, 1);
      push(K_PRE, base + 1650 - PRE, 0);
      push(K_DER, base + 1650, 1 << 16);
      push(K_DLY, base + 1650 + DLY, 0);
      wait_until(base + 1650 + 1000);
      chk("default_line_queue", 64'(evq.size()), 64'd0);
      chk("default_mid_line_x", 64'(x), 64'd1000);
      mon_on = 1'b0;
      #2 rst = 1'b0;
      #1 chk("async_reset_outputs", all_outs(), 64'd0);
      enable = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      evq.delete();
   endtask

   initial begin
      int n, base0;
      #2 chk("reset_outputs", all_outs(), 64'd0);
      tick();
      rst = 1'b1;
      tick();
      tick();
      chk("idle_outputs", all_outs(), 64'd0);

      default_run();
      default_run();

      set_cfg(8, 4, 2, 4, 2, 1);
      tick();
      tick();
      chk("idle_after_cfg", 64'(running_o), 64'd0);
      n = cyc;
      enable = 1'b1;
      base0 = n + 4;
      mon_on = 1'b1;
      push_frame(base0,       8, 4, 2, 4, 2, 1, 1, 6);
      push_frame(base0 + 72,  6, 4, 4, 1, 3, 1, 2, 4);
      push_frame(base0 + 112, 6, 4, 4, 1, 3, 1, 3, 4);
      push_frame(base0 + 152, 6, 4, 4, 1, 3, 1, 4, 4);
      push(K_RUNF, base0 + 193, 0);
      wait_until(base0 + 20);
      set_cfg(6, 4, 10, 0, 3, 1);
      wait_until(base0 + 115);
      enable = 1'b0;
      wait_until(base0 + 125);
      enable = 1'b1;
      wait_until(base0 + 160);
      enable = 1'b0;
      wait_until(base0 + 192);
      chk("drain_running_high", 64'(running_o), 64'd1);
      wait_until(base0 + 215);
      chk("small_cfg_queue", 64'(evq.size()), 64'd0);
      chk("frame_cnt_stopped", 64'(frame_cnt), 64'd4);
      chk("stopped_running", 64'(running_o), 64'd0);
      chk("stopped_de_dly", 64'(de_dly_o), 64'd0);
      mon_on = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
